// File: rtl/dsp_overpack_unpack_acc.sv
// dsp_overpack_unpack_acc: splits the 48-bit overpacked DSP product into six corrected
// signed lane products and accumulates each lane over ACC_LEN beats; final beat accepted
// at t gives acc_valid at t+2; p_ready drops from final-beat acceptance until acc_out is
// handed off, and acc_out/acc_valid hold while acc_ready is low.
// Optional macro ACC_SAT_EN: saturating lane adds plus a sticky sat_flag output.
module dsp_overpack_unpack_acc #(
  parameter int ACC_LEN = 16,
  parameter int ACC_W   = 20,
  parameter int LANE_SP = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [47:0]        p_in,
  input  logic               p_valid,
  output logic               p_ready,
  output logic [6*ACC_W-1:0] acc_out,
  output logic               acc_valid,
  input  logic               acc_ready,
  output logic               busy
`ifdef ACC_SAT_EN
  ,
  output logic               sat_flag
`endif
);

  localparam int NLANE = 6;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;
  typedef logic [NLANE-1:0][8:0]       lane_q_t;
  typedef logic [NLANE-1:0][ACC_W-1:0] lane_acc_t;

  state_t           state_q, state_d;
  logic             p_ready_q, p_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_vld_q, s1_vld_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q, s1_last_d;
  lane_q_t          s1_dat_q, s1_dat_d;
  logic             s2_vld_q, s2_vld_d;
  lane_acc_t        acc_q, acc_d;
  lane_acc_t        acc_out_q, acc_out_d;
  logic             acc_valid_q, acc_valid_d;

  lane_q_t          q_dec;
  logic [NLANE-1:0] borrow;
  lane_acc_t        a_op, b_op, lane_sum;
  logic             accept, in_last, s1_final, handoff;
  logic             unused_hi;

`ifdef ACC_SAT_EN
  logic [NLANE-1:0][ACC_W:0] s_ext;
  logic [NLANE-1:0]          ovf;
  logic [NLANE-1:0]          lane_ovf_q, lane_ovf_d;
  logic                      sat_q, sat_d;
`endif

  // Lane decode: sign-extended 8-bit field plus the borrow left by a negative lower lane
  always_comb begin
    borrow = '0;
    for (int k = 1; k < NLANE; k++) borrow[k] = p_in[LANE_SP*k-1];
    for (int k = 0; k < NLANE; k++) begin
      q_dec[k] = {p_in[LANE_SP*k+7], p_in[LANE_SP*k +: 8]} + {8'd0, borrow[k]};
    end
  end

  // The packer leaves the top bits without meaning
  assign unused_hi = ^p_in[47:38];

  // Per-lane accumulate of the stage-1 product; the first beat of a group restarts the sum
  always_comb begin
    for (int k = 0; k < NLANE; k++) begin
      a_op[k] = s1_first_q ? '0 : acc_q[k];
      b_op[k] = ACC_W'($signed(s1_dat_q[k]));
`ifdef ACC_SAT_EN
      s_ext[k] = {a_op[k][ACC_W-1], a_op[k]} + {b_op[k][ACC_W-1], b_op[k]};
      ovf[k]   = s_ext[k][ACC_W] ^ s_ext[k][ACC_W-1];
      if (ovf[k]) begin
        lane_sum[k] = s_ext[k][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        lane_sum[k] = s_ext[k][ACC_W-1:0];
      end
`else
      lane_sum[k] = a_op[k] + b_op[k];
`endif
    end
  end

  // Handshakes, beat counter, stage capture and ACCUM/HOLD next state
  always_comb begin
    accept   = p_valid & p_ready_q;
    in_last  = (cnt_q == CNT_LAST);
    s1_final = s1_vld_q & s1_last_q;
    handoff  = (state_q == HOLD) & acc_valid_q & acc_ready;

    cnt_d       = cnt_q;
    s1_vld_d    = accept;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_dat_d    = s1_dat_q;
    s2_vld_d    = s1_vld_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = acc_valid_q;
    state_d     = state_q;
`ifdef ACC_SAT_EN
    lane_ovf_d  = lane_ovf_q;
    sat_d       = sat_q;
`endif

    if (accept) begin
      cnt_d      = in_last ? '0 : cnt_q + 1'b1;
      s1_first_d = (cnt_q == '0);
      s1_last_d  = in_last;
      s1_dat_d   = q_dec;
    end

    if (s1_vld_q) begin
      acc_d = lane_sum;
`ifdef ACC_SAT_EN
      lane_ovf_d = (s1_first_q ? '0 : lane_ovf_q) | ovf;
`endif
    end

    if (s1_final) begin
      acc_out_d   = lane_sum;
      acc_valid_d = 1'b1;
      state_d     = HOLD;
`ifdef ACC_SAT_EN
      sat_d       = |lane_ovf_d;
`endif
    end

    if (handoff) begin
      acc_valid_d = 1'b0;
      state_d     = ACCUM;
`ifdef ACC_SAT_EN
      sat_d       = 1'b0;
`endif
    end

    // Input closes from final-beat acceptance until the result is handed off
    p_ready_d = (state_d == ACCUM) & ~(accept & in_last);
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ACCUM;
      p_ready_q   <= 1'b0;
      cnt_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_dat_q    <= '0;
      s2_vld_q    <= 1'b0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
`ifdef ACC_SAT_EN
      lane_ovf_q  <= '0;
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      p_ready_q   <= p_ready_d;
      cnt_q       <= cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_dat_q    <= s1_dat_d;
      s2_vld_q    <= s2_vld_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
`ifdef ACC_SAT_EN
      lane_ovf_q  <= lane_ovf_d;
      sat_q       <= sat_d;
`endif
    end
  end

  assign p_ready   = p_ready_q;
  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign busy      = s1_vld_q | s2_vld_q | acc_valid_q;
`ifdef ACC_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_dsp_overpack_unpack_acc.sv
// Bench for dsp_overpack_unpack_acc: three instances (ACC_LEN=1/W=20, ACC_LEN=4/W=20,
// ACC_LEN=4/W=9) share one stimulus port set; sel routes valid/ready to the active one.
module tb_dsp_overpack_unpack_acc;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic [47:0] p_in;
  logic        p_valid;
  logic        acc_ready;
  int          sel;

  logic pv0, pv1, pv2, ar0, ar1, ar2;
  logic pr0, pr1, pr2, av0, av1, av2, bz0, bz1, bz2;
  logic [119:0] ao0, ao1;
  logic [53:0]  ao2;
`ifdef ACC_SAT_EN
  logic st0, st1, st2, sat_m, last_sat;
`endif

  assign pv0 = p_valid && (sel == 0);
  assign pv1 = p_valid && (sel == 1);
  assign pv2 = p_valid && (sel == 2);
  assign ar0 = acc_ready || (sel != 0);
  assign ar1 = acc_ready || (sel != 1);
  assign ar2 = acc_ready || (sel != 2);

  dsp_overpack_unpack_acc #(.ACC_LEN(1), .ACC_W(20)) u0 (
    .CLK(CLK), .RST(RST), .p_in(p_in), .p_valid(pv0), .p_ready(pr0),
    .acc_out(ao0), .acc_valid(av0), .acc_ready(ar0),
`ifdef ACC_SAT_EN
    .sat_flag(st0),
`endif
    .busy(bz0));

  dsp_overpack_unpack_acc #(.ACC_LEN(4), .ACC_W(20)) u1 (
    .CLK(CLK), .RST(RST), .p_in(p_in), .p_valid(pv1), .p_ready(pr1),
    .acc_out(ao1), .acc_valid(av1), .acc_ready(ar1),
`ifdef ACC_SAT_EN
    .sat_flag(st1),
`endif
    .busy(bz1));

  dsp_overpack_unpack_acc #(.ACC_LEN(4), .ACC_W(9)) u2 (
    .CLK(CLK), .RST(RST), .p_in(p_in), .p_valid(pv2), .p_ready(pr2),
    .acc_out(ao2), .acc_valid(av2), .acc_ready(ar2),
`ifdef ACC_SAT_EN
    .sat_flag(st2),
`endif
    .busy(bz2));

  logic p_ready_m, acc_valid_m, busy_m;
  int   lane_m [6];

  always_comb begin
    p_ready_m   = pr0;
    acc_valid_m = av0;
    busy_m      = bz0;
    for (int k = 0; k < 6; k++) lane_m[k] = $signed(ao0[k*20 +: 20]);
    if (sel == 1) begin
      p_ready_m   = pr1;
      acc_valid_m = av1;
      busy_m      = bz1;
      for (int k = 0; k < 6; k++) lane_m[k] = $signed(ao1[k*20 +: 20]);
    end else if (sel == 2) begin
      p_ready_m   = pr2;
      acc_valid_m = av2;
      busy_m      = bz2;
      for (int k = 0; k < 6; k++) lane_m[k] = $signed(ao2[k*9 +: 9]);
    end
  end

`ifdef ACC_SAT_EN
  always_comb begin
    sat_m = st0;
    if (sel == 1) sat_m = st1;
    else if (sel == 2) sat_m = st2;
  end
`endif

  typedef struct packed {
    logic            sat;
    logic [5:0][31:0] ln;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   failures = 0;
  int   accepts = 0;
  int   handoffs = 0;
  int   macc [6];
  int   mcnt = 0;
  bit   movf = 0;
  int   last_ln [6];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference lane decode: signed 8-bit field at 6k plus the bit just below it
  function automatic int dec(input logic [47:0] w, input int k);
    logic [7:0] f;
    int v;
    f = w[6*k +: 8];
    v = int'($signed(f));
    if (k > 0) v = v + (w[6*k-1] ? 1 : 0);
    return v;
  endfunction

  // Golden packer: lane products summed at 6-bit spacing
  function automatic logic [47:0] pack(input int w0, input int w1, input int a0, input int a1, input int a2);
    longint v;
    int p [6];
    p[0] = w0*a0; p[1] = w0*a1; p[2] = w0*a2;
    p[3] = w1*a0; p[4] = w1*a1; p[5] = w1*a2;
    v = 0;
    for (int k = 0; k < 6; k++) v = v + longint'(p[k]) * (longint'(1) << (6*k));
    return v[47:0];
  endfunction

  // Scoreboard: model pushes on accepted beats, compares on handoff
  initial begin : monitor
    exp_t e;
    int s, v, len, w, lo, hi;
    e = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        mcnt = 0;
        movf = 0;
        for (int k = 0; k < 6; k++) macc[k] = 0;
        sb.delete();
      end else begin
        if (acc_valid_m && acc_ready) begin
          handoffs++;
          chk("sb_nonempty", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 6; k++) chk($sformatf("sel%0d_lane%0d", sel, k), lane_m[k], $signed(e.ln[k]));
`ifdef ACC_SAT_EN
            chk("sat_flag", int'(sat_m), int'(e.sat));
            last_sat = sat_m;
`endif
            for (int k = 0; k < 6; k++) last_ln[k] = lane_m[k];
          end
        end
        if (p_valid && p_ready_m) begin
          accepts++;
          len = (sel == 0) ? 1 : 4;
          w   = (sel == 2) ? 9 : 20;
          lo  = -(1 << (w-1));
          hi  = (1 << (w-1)) - 1;
          if (mcnt == 0) movf = 0;
          for (int k = 0; k < 6; k++) begin
            v = dec(p_in, k);
            s = (mcnt == 0) ? v : macc[k] + v;
`ifdef ACC_SAT_EN
            if (s > hi) begin s = hi; movf = 1; end
            else if (s < lo) begin s = lo; movf = 1; end
`else
            s = s & ((1 << w) - 1);
            if (s > hi) s = s - (1 << w);
`endif
            macc[k] = s;
            e.ln[k] = 32'(s);
          end
          mcnt++;
          if (mcnt == len) begin
            e.sat = movf;
            sb.push_back(e);
            mcnt = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [47:0] w, input bit gap);
    int t;
    t = 0;
    p_in = w;
    p_valid = 1'b1;
    while (!p_ready_m && t < 50) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("send_ready", int'(p_ready_m), 1);
    @(posedge CLK); #1;
    p_valid = 1'b0;
    if (gap) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy_m || !p_ready_m) && t < 100) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("idle", int'(busy_m), 0);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!acc_valid_m && t < 50) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("valid_rise", int'(acc_valid_m), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stim
    int a0, h0, same;
    int snap [6];
    RST = 1'b1; p_valid = 1'b0; p_in = '0; acc_ready = 1'b1; sel = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_p_ready", int'(p_ready_m), 0);
    chk("rst_acc_valid", int'(av0 | av1 | av2), 0);
    chk("rst_busy", int'(bz0 | bz1 | bz2), 0);
    chk("rst_acc_out", int'((ao0 == '0) && (ao1 == '0) && (ao2 == '0)), 1);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("p_ready_after_rst", int'(p_ready_m), 1);

    // ACC_LEN=1: lane0 = 15, exact two-cycle latency
    p_in = 48'h0000_0000_000F; p_valid = 1'b1;
    @(posedge CLK); #1;
    p_valid = 1'b0;
    chk("lat_t1_valid", int'(acc_valid_m), 0);
    chk("lat_t1_p_ready", int'(p_ready_m), 0);
    chk("lat_t1_busy", int'(busy_m), 1);
    @(posedge CLK); #1;
    chk("lat_t2_valid", int'(acc_valid_m), 1);
    @(posedge CLK); #1;
    chk("post_handoff_valid", int'(acc_valid_m), 0);
    chk("post_handoff_p_ready", int'(p_ready_m), 1);
    chk("t1_lane0", last_ln[0], 15);

    // Borrow correction: all-ones upper lanes decode to zero
    send(48'hFFFF_FFFF_FFF6, 1'b0);
    wait_idle();
    chk("t2_lane0", last_ln[0], -10);
    chk("t2_lane1", last_ln[1], 0);

    // ACC_LEN=1 throughput: one group per three cycles under continuous valid
    a0 = accepts;
    p_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      p_in = {$urandom, $urandom};
      @(posedge CLK); #1;
    end
    p_valid = 1'b0;
    chk("thru_accepts", accepts - a0, 3);
    wait_idle();

    // ACC_LEN=4 with golden-packed words
    sel = 1;
    wait_idle();
    for (int i = 0; i < 4; i++) send(pack(-8, 7, 15, 15, 15), 1'b0);
    wait_idle();
    chk("pack_lane0", last_ln[0], -480);

    // Gapped input, consumer stalls ten cycles, input held valid meanwhile
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 1'b1);
    wait_valid();
    for (int k = 0; k < 6; k++) snap[k] = lane_m[k];
    p_valid = 1'b1; p_in = {$urandom, $urandom};
    h0 = handoffs;
    for (int i = 0; i < 10; i++) begin
      same = 1;
      for (int k = 0; k < 6; k++) if (lane_m[k] != snap[k]) same = 0;
      chk("hold_valid", int'(acc_valid_m), 1);
      chk("hold_p_ready", int'(p_ready_m), 0);
      chk("hold_stable", same, 1);
      @(posedge CLK); #1;
    end
    chk("hold_no_handoff", handoffs - h0, 0);
    p_valid = 1'b0; acc_ready = 1'b1;
    @(posedge CLK); #1;
    chk("release_p_ready", int'(p_ready_m), 1);
    chk("release_valid", int'(acc_valid_m), 0);
    for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 1'b0);
    wait_idle();

    // Reset drops a pending result
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 1'b0);
    wait_valid();
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_drop_valid", int'(acc_valid_m), 0);
    RST = 1'b0; acc_ready = 1'b1;
    @(posedge CLK); #1;

    // Reset mid-group, then a clean group of 15s
    for (int i = 0; i < 2; i++) send({$urandom, $urandom}, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_mid_valid", int'(acc_valid_m), 0);
    chk("rst_mid_busy", int'(busy_m), 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) send(48'd15, 1'b0);
    wait_idle();
    chk("rst_group_lane0", last_ln[0], 60);

    // ACC_W=9: saturation or wrap of lane0 = 4 x 105
    sel = 2;
    wait_idle();
    for (int i = 0; i < 4; i++) send(48'd105, 1'b0);
    wait_idle();
`ifdef ACC_SAT_EN
    chk("sat_lane0", last_ln[0], 255);
    chk("sat_flag_set", int'(last_sat), 1);
`else
    chk("wrap_lane0", last_ln[0], -92);
`endif
    chk("wrap_lane1", last_ln[1], 8);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
